cbua_mod: RTL

Modulo-N up counter with a carry-in/carry-out cascade. It counts up from 0 to a programmable terminal count (TC), then wraps to 0. It pairs with the down-counter cells in the same macro library. Slices chain into wider up counters through CAI/CAO, and the terminal-count register allows arbitrary divide-by-N without external compare logic.

---
 rtl/cbua_mod.sv | 89 ++++++++
 1 files changed

// File: rtl/cbua_mod.sv
// Modulo-N up counter slice with carry-in/carry-out cascade and a loadable terminal count.
// Optional sticky out-of-range flag OVF is built only when CBUA_MOD_OVF_EN is defined.
module cbua_mod #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] TC_RESET = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             CDN,
    input  logic             SCLR,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             CAI,
    input  logic             TCLD,
    input  logic [WIDTH-1:0] TCD,
    input  logic             OVFCLR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] TCQ,
    output logic             TC,
    output logic             CAO,
    output logic             OVF
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] term;
    logic             step;
    logic             at_term;

    assign step    = CAI & EN;
    assign at_term = (count == term);

    assign Q   = count;
    assign TCQ = term;
    assign TC  = at_term;
    assign CAO = step & at_term;

    // Out-of-range values (after LD or a lowered TCQ) simply roll through all-ones to zero.
    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            count <= '0;
        end else if (SCLR) begin
            count <= '0;
        end else if (LD) begin
            count <= D;
        end else if (step) begin
            if (at_term) begin
                count <= '0;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

    // The wrap compare above sees the old value on a same-edge TCLD.
    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            term <= TC_RESET;
        end else if (TCLD) begin
            term <= TCD;
        end
    end

`ifdef CBUA_MOD_OVF_EN
    logic ovf_flag;
    logic ovf_set;

    assign ovf_set = step & ~SCLR & ~LD & (count > term);

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            ovf_flag <= 1'b0;
        end else if (SCLR) begin
            ovf_flag <= 1'b0;
        end else if (ovf_set) begin
            ovf_flag <= 1'b1;
        end else if (OVFCLR) begin
            ovf_flag <= 1'b0;
        end
    end

    assign OVF = ovf_flag;
`else
    logic unused_ovfclr;

    assign unused_ovfclr = OVFCLR;
    assign OVF           = 1'b0;
`endif

endmodule
